// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file.
// Build option: define REGFILE_BYPASS_EN for write-first (forwarding) reads.
package regfile_pkg;

    localparam int REGFILE_WIDTH_DEF = 4;
    localparam int REGFILE_DEPTH_DEF = 8;

    // Read/write ordering on a same-cycle collision; lets benches name the mode.
    typedef enum logic {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } regfile_mode_e;

    // Address width, never below one bit so a degenerate depth still has a port.
    function automatic int regfile_aw(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// DEPTH:1 combinational read select over a flattened register array.
// Addresses at or beyond DEPTH yield zero.
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH_DEF,
    parameter int DEPTH = REGFILE_DEPTH_DEF,
    parameter int AW    = regfile_aw(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] flat,
    input  logic [AW-1:0]          addr,
    output logic [WIDTH-1:0]       data
);

    // Pick the addressed entry; no match (out of range) leaves the zero default.
    always_comb begin
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) begin
                data = flat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one synchronous write port, two registered
// read ports with one-cycle valid strobes, synchronous bulk clear and
// out-of-range address protection.
// Build option: REGFILE_BYPASS_EN selects write-first reads (forwarding);
// undefined gives read-first reads from the array only.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH_DEF,
    parameter int DEPTH = REGFILE_DEPTH_DEF,
    parameter int AW    = regfile_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic [WIDTH-1:0]       mux_a;
    logic [WIDTH-1:0]       mux_b;
    logic [WIDTH-1:0]       nxt_a;
    logic [WIDTH-1:0]       nxt_b;
    logic                   wr_ok;

    // A write lands only when not overridden by clear and the address exists.
    assign wr_ok = we && !clr && (32'(waddr) < DEPTH);

    // Register array: async reset, clear beats write, out-of-range writes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Present the array as one flat vector for the read selectors.
    always_comb begin
        mem_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem[i];
        end
    end

    regfile_read_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mux_a (
        .flat (mem_flat),
        .addr (raddr_a),
        .data (mux_a)
    );

    regfile_read_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mux_b (
        .flat (mem_flat),
        .addr (raddr_b),
        .data (mux_b)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-first: a same-cycle clear reads as zero, a landing write forwards.
    // Matching on wr_ok keeps out-of-range reads at zero even when waddr matches.
    always_comb begin
        nxt_a = mux_a;
        nxt_b = mux_b;
        if (clr) begin
            nxt_a = '0;
            nxt_b = '0;
        end else begin
            if (wr_ok && (raddr_a == waddr)) nxt_a = wdata;
            if (wr_ok && (raddr_b == waddr)) nxt_b = wdata;
        end
    end
`else
    // Read-first: the array contents from before the edge are returned.
    always_comb begin
        nxt_a = mux_a;
        nxt_b = mux_b;
    end
`endif

    // Port A output stage: valid strobes per request, data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a  <= '0;
            rvalid_a <= 1'b0;
        end else begin
            rvalid_a <= re_a;
            if (re_a) rdata_a <= nxt_a;
        end
    end

    // Port B output stage: identical behaviour to port A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_b  <= '0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_b <= re_b;
            if (re_b) rdata_b <= nxt_b;
        end
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port and two independent registered read ports. It supersedes the fixed 8-input combinational read-select mux used in the lab register file. It adds a registered read path with valid strobes, synchronous bulk clear, out-of-range address protection and optional write-to-read forwarding. It sits between the lab datapath and its operand latches.

Parameters:
WIDTH, 4, bits per register (1..64)
DEPTH, 8, number of registers (2..64, need not be a power of two)
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
clr  in  1  synchronous clear of all registers to 0
re_a  in  1  read request, port A
raddr_a  in  AW  read address, port A
rdata_a  out  WIDTH  read data, port A (registered)
rvalid_a  out  1  one-cycle strobe, rdata_a is valid
re_b, raddr_b, rdata_b, rvalid_b  same as port A, port B

Behaviour:
- Reset: on rst assertion, immediately and asynchronously set all DEPTH registers, rdata_a/b and rvalid_a/b to 0. Outputs hold 0 while rst is high. The first edge after deassertion behaves normally.
- Write: on a clk edge with we=1, clr=0 and waddr<DEPTH, mem[waddr]<=wdata. A write with waddr>=DEPTH is silently dropped.
- Clear: on a clk edge with clr=1, all registers <=0. clr beats a same-cycle we, so the write is dropped.
- Read latency is 1 cycle. When re_x=1 at edge N, rdata_x holds the selected value and rvalid_x=1 after edge N.
- When re_x=0 at an edge, rvalid_x<=0 and rdata_x holds its previous value. rdata is not zeroed.
- A read with raddr_x>=DEPTH returns 0 with rvalid_x=1.
- Both ports may read the same or different addresses in the same cycle with no conflict.
- Same-cycle read and write to the same address:
  - with forwarding: rdata=wdata
  - without forwarding: rdata=old contents
- Same-cycle read and clr: rdata=0 with forwarding, old contents without.
- Reset mid-operation: a pending read is discarded. rvalid is 0 on the first post-reset edge unless re is high at that edge.
- No state machine. State is the register array plus 2x(rdata, rvalid) pipeline registers.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: the read path compares raddr_x with waddr when we=1 and clr=0, and selects wdata on a match. When clr=1 it selects 0. This is write-first semantics.
- Undefined: the read path reads the array only. This is read-first semantics, and the read returns the value present before the edge.
- No port-list change either way.

Decomposition:
- Package regfile_pkg holds:
  - localparam defaults REGFILE_WIDTH_DEF=4 and REGFILE_DEPTH_DEF=8
  - a function regfile_aw(depth) returning max(1,$clog2(depth))
  - typedef enum {RD_FIRST, WR_FIRST} for documenting the bypass mode in benches
- One sub-module, regfile_read_mux:
  - parametrised DEPTH:1, WIDTH-bit combinational select over a flattened array
  - returns 0 for an out-of-range address
  - instantiated twice, once per port, ahead of the output registers

Test Plan:
1. Reset and write: assert rst mid-run, then write 4'hA to addr 3 and re_a addr 3 -> rdata_a/rvalid_a=0 during rst; after the write, the following read gives rdata_a=4'hA with rvalid_a high for exactly 1 cycle.
2. Dual read: fill mem[i]=i+1, then in the same cycle re_a addr 0 and re_b addr 7 -> next cycle rdata_a=1, rdata_b=8, both rvalid=1.
3. Same-cycle read/write: mem[5]=4'h2, then we to addr 5 with 4'h9 while re_a addr 5 -> rdata_a=4'h9 with REGFILE_BYPASS_EN defined, 4'h2 without; a follow-up read gives 4'h9 in both builds.
4. Clear priority: clr=1 and we addr 2 with 4'hF in the same cycle -> all registers 0; a read of addr 2 gives 0.
5. Out of range: DEPTH=6, write 4'h7 to addr 6, then read addr 6 -> rdata=0 with rvalid=1; mem[0..5] unchanged.
6. Hold: re_a high for one cycle then low for 3 cycles -> rvalid_a is 1 then 0,0,0; rdata_a holds its value for all 3 cycles.
